// File: rtl/alu_mul_pkg.sv
// Shared constants for the queued ALU/multiplier slave: opcodes, register map,
// STATUS bit positions and engine state encoding.
package alu_mul_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_NOT = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_LSL = 4'h6;
    localparam logic [3:0] OP_LSR = 4'h7;
    localparam logic [3:0] OP_ASR = 4'h8;
    localparam logic [3:0] OP_MUL = 4'hD;

    localparam logic [3:0] ADDR_OPA    = 4'h0;
    localparam logic [3:0] ADDR_OPB    = 4'h1;
    localparam logic [3:0] ADDR_OPCODE = 4'h2;
    localparam logic [3:0] ADDR_PUSH   = 4'h3;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CLEAR  = 4'h5;
    localparam logic [3:0] ADDR_RES_LO = 4'h6;
    localparam logic [3:0] ADDR_RES_HI = 4'h7;
    localparam logic [3:0] ADDR_POP    = 4'h8;
    localparam logic [3:0] ADDR_IRQ_EN = 4'h9;

    localparam int STAT_CMD_FULL  = 0;
    localparam int STAT_CMD_EMPTY = 1;
    localparam int STAT_RES_FULL  = 2;
    localparam int STAT_RES_EMPTY = 3;
    localparam int STAT_BUSY      = 4;
    localparam int STAT_OVERFLOW  = 5;
    localparam int STAT_UNDERFLOW = 6;
    localparam int STAT_BAD_OP    = 7;
    localparam int STAT_CMD_CNT   = 8;
    localparam int STAT_RES_CNT   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALU,
        ST_MUL,
        ST_POST
    } eng_state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_ASR;
    endfunction

endpackage

// File: rtl/alu_mul_queue_slave_sync_fifo.sv
// Single-clock FIFO with flush. A pop and a push in the same cycle are both
// accepted even when full, since the pop frees the slot first.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_mul_queue_slave.sv
// Queued bus-slave ALU with a sequential signed shift-add multiplier.
// Define ALUMUL_IRQ_EN to add the irq output and the IRQ_EN register.
module alu_mul_queue_slave
    import alu_mul_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              S_sel,
    input  logic              S_wr,
    input  logic [7:0]        S_addr,
    input  logic [DATA_W-1:0] S_din,
    output logic [DATA_W-1:0] S_dout
`ifdef ALUMUL_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int CMD_W  = 2 * DATA_W + 4;
    localparam int RES_W  = 2 * DATA_W;
    localparam int SH_W   = $clog2(DATA_W);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int STEP_W = $clog2(DATA_W) + 1;

    logic [3:0] addr;
    logic       wr_en, bus_push, bus_pop, bus_clear;

    assign addr      = S_addr[3:0];
    assign wr_en     = S_sel && S_wr;
    assign bus_push  = wr_en && (addr == ADDR_PUSH)  && S_din[0];
    assign bus_pop   = wr_en && (addr == ADDR_POP)   && S_din[0];
    assign bus_clear = wr_en && (addr == ADDR_CLEAR) && S_din[0];

    logic [DATA_W-1:0] opa_q, opb_q;
    logic [3:0]        opc_q;
    logic              ovf_q, udf_q, bad_q;

    logic [CMD_W-1:0]  cmd_dout;
    logic              cmd_full, cmd_empty;
    logic [CW-1:0]     cmd_count;
    logic [RES_W-1:0]  res_dout;
    logic              res_full, res_empty;
    logic [CW-1:0]     res_count;
    logic              eng_pop, eng_push;

    eng_state_e        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic [RES_W-1:0]  acc_q, acc_d, mcand_q, mcand_d, res_q, res_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              bad_set;
    logic [DATA_W-1:0] alu_y;

    logic [DATA_W-1:0] cmd_a, cmd_b;
    logic [3:0]        cmd_op;

    assign cmd_a  = cmd_dout[CMD_W-1 -: DATA_W];
    assign cmd_b  = cmd_dout[4 +: DATA_W];
    assign cmd_op = cmd_dout[3:0];

    assign eng_pop  = (state_q == ST_IDLE) && !cmd_empty;
    assign eng_push = (state_q == ST_POST) && (!res_full || bus_pop);

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (bus_clear),
        .push    (bus_push),
        .pop     (eng_pop),
        .din     ({opa_q, opb_q, opc_q}),
        .dout    (cmd_dout),
        .full    (cmd_full),
        .empty   (cmd_empty),
        .count   (cmd_count)
    );

    sync_fifo #(.WIDTH(RES_W), .DEPTH(FIFO_DEPTH)) u_res_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (bus_clear),
        .push    (eng_push),
        .pop     (bus_pop),
        .din     (res_q),
        .dout    (res_dout),
        .full    (res_full),
        .empty   (res_empty),
        .count   (res_count)
    );

    always_comb begin
        alu_y = '0;
        case (op_q)
            OP_AND:  alu_y = a_q & b_q;
            OP_OR:   alu_y = a_q | b_q;
            OP_XOR:  alu_y = a_q ^ b_q;
            OP_NOT:  alu_y = ~a_q;
            OP_ADD:  alu_y = a_q + b_q;
            OP_SUB:  alu_y = a_q - b_q;
            OP_LSL:  alu_y = a_q << b_q[SH_W-1:0];
            OP_LSR:  alu_y = a_q >> b_q[SH_W-1:0];
            OP_ASR:  alu_y = $unsigned($signed(a_q) >>> b_q[SH_W-1:0]);
            default: alu_y = '0;
        endcase
    end

    // Multiplier: one B bit per step, LSB first. The B sign bit carries weight
    // -2^(DATA_W-1), so its partial product is subtracted. Step value DATA_W is
    // the wrap-up cycle that hands the product to the result register.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        step_d   = step_q;
        res_d    = res_q;
        bad_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cmd_empty) begin
                    a_d      = cmd_a;
                    b_d      = cmd_b;
                    op_d     = cmd_op;
                    acc_d    = '0;
                    mcand_d  = {{DATA_W{cmd_a[DATA_W-1]}}, cmd_a};
                    mplier_d = cmd_b;
                    step_d   = '0;
                    state_d  = (cmd_op == OP_MUL) ? ST_MUL : ST_ALU;
                end
            end
            ST_ALU: begin
                res_d   = {{DATA_W{1'b0}}, alu_y};
                bad_set = !is_alu_op(op_q);
                state_d = ST_POST;
            end
            ST_MUL: begin
                if (step_q == STEP_W'(DATA_W)) begin
                    res_d   = acc_q;
                    state_d = ST_POST;
                end else begin
                    if (mplier_q[0])
                        acc_d = (step_q == STEP_W'(DATA_W - 1)) ? acc_q - mcand_q
                                                                 : acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    step_d   = step_q + 1'b1;
                end
            end
            ST_POST: begin
                if (eng_push) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus_clear) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            step_q   <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            step_q   <= step_d;
            res_q    <= res_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q <= '0;
            opb_q <= '0;
            opc_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            bad_q <= 1'b0;
        end else if (bus_clear) begin
            opa_q <= '0;
            opb_q <= '0;
            opc_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            if (wr_en && addr == ADDR_OPA)    opa_q <= S_din;
            if (wr_en && addr == ADDR_OPB)    opb_q <= S_din;
            if (wr_en && addr == ADDR_OPCODE) opc_q <= S_din[3:0];
            // A push into a full queue survives only if the engine drains it this cycle.
            if (bus_push && cmd_full && !eng_pop) ovf_q <= 1'b1;
            if (bus_pop && res_empty)             udf_q <= 1'b1;
            if (bad_set)                          bad_q <= 1'b1;
        end
    end

`ifdef ALUMUL_IRQ_EN
    logic [1:0] irq_en_q;
    logic       irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_en && addr == ADDR_IRQ_EN) irq_en_q <= S_din[1:0];
            irq_q <= (irq_en_q[0] && !res_empty) ||
                     (irq_en_q[1] && (ovf_q || udf_q || bad_q));
        end
    end

    assign irq = irq_q;
`endif

    logic [31:0]       st;
    logic [DATA_W-1:0] rdata;
    logic              bus_unused;

    always_comb begin
        st                 = '0;
        st[STAT_CMD_FULL]  = cmd_full;
        st[STAT_CMD_EMPTY] = cmd_empty;
        st[STAT_RES_FULL]  = res_full;
        st[STAT_RES_EMPTY] = res_empty;
        st[STAT_BUSY]      = (state_q != ST_IDLE) || !cmd_empty;
        st[STAT_OVERFLOW]  = ovf_q;
        st[STAT_UNDERFLOW] = udf_q;
        st[STAT_BAD_OP]    = bad_q;
        st[STAT_CMD_CNT +: 8] = 8'(cmd_count);
        st[STAT_RES_CNT +: 8] = 8'(res_count);
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_OPA:    rdata = opa_q;
            ADDR_OPB:    rdata = opb_q;
            ADDR_OPCODE: rdata = {{(DATA_W-4){1'b0}}, opc_q};
            ADDR_STATUS: rdata = st[DATA_W-1:0];
            ADDR_RES_LO: rdata = res_empty ? '0 : res_dout[DATA_W-1:0];
            ADDR_RES_HI: rdata = res_empty ? '0 : res_dout[RES_W-1:DATA_W];
`ifdef ALUMUL_IRQ_EN
            ADDR_IRQ_EN: rdata = {{(DATA_W-2){1'b0}}, irq_en_q};
`endif
            default:     rdata = '0;
        endcase
    end

    assign S_dout     = (S_sel && !S_wr) ? rdata : '0;
    assign bus_unused = ^{S_addr[7:4], st};

endmodule

// File: tb/tb_alu_mul_queue_slave.sv
// Scoreboard bench: bus reads queue their expected value, a negedge monitor
// pops and compares whenever the DUT is driving read data.
module tb_alu_mul_queue_slave;
    import alu_mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        S_sel, S_wr;
    logic [7:0]  S_addr;
    logic [31:0] S_din;
    logic [31:0] S_dout;
`ifdef ALUMUL_IRQ_EN
    logic        irq;
    logic        irq_probe = 1'b0;
    typedef struct { string name; logic val; } iexp_t;
    iexp_t       irq_q[$];
`endif

    typedef struct { string name; logic [31:0] val; } exp_t;
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    alu_mul_queue_slave #(.DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .S_sel   (S_sel),
        .S_wr    (S_wr),
        .S_addr  (S_addr),
        .S_din   (S_din),
        .S_dout  (S_dout)
`ifdef ALUMUL_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        if (S_sel && !S_wr) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got %h, nothing expected", S_dout);
            end else begin
                e = exp_q.pop_front();
                if (S_dout !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, S_dout, e.val);
                end
            end
        end
`ifdef ALUMUL_IRQ_EN
        if (irq_probe) begin
            iexp_t ie;
            checks++;
            if (irq_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_irq_probe: got %b", irq);
            end else begin
                ie = irq_q.pop_front();
                if (irq !== ie.val) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", ie.name, irq, ie.val);
                end
            end
        end
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        S_sel = 1'b1; S_wr = 1'b1; S_addr = {4'h0, a}; S_din = d;
        @(posedge clk);
        #1;
        S_sel = 1'b0; S_wr = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
        exp_t x;
        x.name = n;
        x.val  = e;
        exp_q.push_back(x);
        S_sel = 1'b1; S_wr = 1'b0; S_addr = {4'h0, a};
        @(posedge clk);
        #1;
        S_sel = 1'b0;
    endtask

    task automatic stage(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        wr(ADDR_OPA, a);
        wr(ADDR_OPB, b);
        wr(ADDR_OPCODE, {28'h0, op});
    endtask

    task automatic alu_check(input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op, input logic [31:0] lo, input string n);
        stage(a, b, op);
        wr(ADDR_PUSH, 32'h1);
        idle(3);
        rd(ADDR_RES_LO, lo, n);
        rd(ADDR_RES_HI, 32'h0, {n, "_hi"});
        wr(ADDR_POP, 32'h1);
    endtask

`ifdef ALUMUL_IRQ_EN
    task automatic irq_chk(input logic e, input string n);
        iexp_t x;
        x.name = n;
        x.val  = e;
        irq_q.push_back(x);
        irq_probe = 1'b1;
        @(posedge clk);
        #1;
        irq_probe = 1'b0;
    endtask
`endif

    // Directed ALU vectors: {A, B, opcode, expected RES_LO}
    typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] op; logic [31:0] y; } vec_t;
    vec_t vecs[7];

    initial begin
        vecs[0] = '{32'h0000000C, 32'h0000000A, OP_OR,  32'h0000000E};
        vecs[1] = '{32'h0F0F0F0F, 32'h00000000, OP_NOT, 32'hF0F0F0F0};
        vecs[2] = '{32'h00000005, 32'h00000007, OP_SUB, 32'hFFFFFFFE};
        vecs[3] = '{32'h00000001, 32'h00000021, OP_LSL, 32'h00000002};
        vecs[4] = '{32'h80000000, 32'h00000004, OP_LSR, 32'h08000000};
        vecs[5] = '{32'h80000000, 32'h00000004, OP_ASR, 32'hF8000000};
        vecs[6] = '{32'hFFFF0000, 32'h0FF00FF0, OP_AND, 32'h0FF00000};

        reset_n = 1'b0; S_sel = 1'b0; S_wr = 1'b0; S_addr = '0; S_din = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        rd(ADDR_STATUS, 32'h0000000A, "reset_status");
        rd(ADDR_RES_LO, 32'h0, "reset_res_lo");
        rd(ADDR_OPA,    32'h0, "reset_opa");

        // ADD latency: result lands on the third edge after PUSH
        stage(7, 5, OP_ADD);
        wr(ADDR_PUSH, 32'h1);
        idle(2);
        rd(ADDR_STATUS, 32'h0000001A, "add_status_before");
        rd(ADDR_STATUS, 32'h00010002, "add_status_after");
        rd(ADDR_RES_LO, 32'd12, "add_res_lo");
        rd(ADDR_RES_HI, 32'h0,  "add_res_hi");
        wr(ADDR_POP, 32'h1);
        rd(ADDR_STATUS, 32'h0000000A, "add_status_popped");
        rd(ADDR_OPCODE, 32'h4, "staging_kept");

        foreach (vecs[i]) alu_check(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].y, $sformatf("alu_vec%0d", i));

        // MUL latency DATA_W+3
        stage(32'hFFFFFFFD, 32'h4, OP_MUL);
        wr(ADDR_PUSH, 32'h1);
        idle(34);
        rd(ADDR_STATUS, 32'h0000001A, "mul_status_before");
        rd(ADDR_STATUS, 32'h00010002, "mul_status_after");
        rd(ADDR_RES_LO, 32'hFFFFFFF4, "mul_neg_lo");
        rd(ADDR_RES_HI, 32'hFFFFFFFF, "mul_neg_hi");
        wr(ADDR_POP, 32'h1);

        stage(32'h7FFFFFFF, 32'h7FFFFFFF, OP_MUL);
        wr(ADDR_PUSH, 32'h1);
        idle(35);
        rd(ADDR_RES_LO, 32'h00000001, "mul_max_lo");
        rd(ADDR_RES_HI, 32'h3FFFFFFF, "mul_max_hi");
        wr(ADDR_POP, 32'h1);

        // Queue ordering and back-pressure
        stage(7, 5, OP_ADD);
        wr(ADDR_PUSH, 32'h1);
        wr(ADDR_OPCODE, OP_SUB);
        wr(ADDR_PUSH, 32'h1);
        wr(ADDR_OPCODE, OP_XOR);
        wr(ADDR_PUSH, 32'h1);
        stage(3, 3, OP_MUL);
        wr(ADDR_PUSH, 32'h1);
        idle(60);
        wr(ADDR_OPCODE, OP_ADD);
        repeat (6) wr(ADDR_PUSH, 32'h1);
        rd(ADDR_STATUS, 32'h00040435, "q_full_overflow");
        rd(ADDR_RES_LO, 32'd12, "q_pop0");
        wr(ADDR_POP, 32'h1);
        rd(ADDR_RES_LO, 32'd2, "q_pop1");
        wr(ADDR_POP, 32'h1);
        rd(ADDR_RES_LO, 32'd2, "q_pop2");
        wr(ADDR_POP, 32'h1);
        rd(ADDR_RES_LO, 32'd9, "q_pop3");
        rd(ADDR_RES_HI, 32'd0, "q_pop3_hi");
        wr(ADDR_POP, 32'h1);
        rd(ADDR_RES_LO, 32'd6, "q_stalled_result");

        wr(ADDR_CLEAR, 32'h1);
        rd(ADDR_STATUS, 32'h0000000A, "clear_status");
        rd(ADDR_OPA,    32'h0, "clear_opa");

        // Error flags
        wr(ADDR_POP, 32'h1);
        rd(ADDR_STATUS, 32'h0000004A, "underflow");
        stage(1, 2, 4'hF);
        wr(ADDR_PUSH, 32'h1);
        idle(3);
        rd(ADDR_RES_LO, 32'h0, "badop_res");
        rd(ADDR_STATUS, 32'h000100C2, "badop_status");
        wr(ADDR_CLEAR, 32'h1);

        // Reset during MUL step 10
        stage(32'h12345678, 32'h9, OP_MUL);
        wr(ADDR_PUSH, 32'h1);
        idle(11);
        reset_n = 1'b0;
        rd(ADDR_STATUS, 32'h0000000A, "rstmul_status");
        rd(ADDR_RES_LO, 32'h0, "rstmul_res_lo");
        rd(ADDR_OPB,    32'h0, "rstmul_opb");
        reset_n = 1'b1;
        idle(40);
        rd(ADDR_STATUS, 32'h0000000A, "rstmul_no_result");
        alu_check(1, 1, OP_ADD, 32'd2, "rstmul_add");

`ifdef ALUMUL_IRQ_EN
        wr(ADDR_IRQ_EN, 32'h1);
        rd(ADDR_IRQ_EN, 32'h1, "irq_en_rd");
        stage(2, 2, OP_ADD);
        wr(ADDR_PUSH, 32'h1);
        idle(3);
        irq_chk(1'b0, "irq_not_yet");
        irq_chk(1'b1, "irq_rise");
        rd(ADDR_RES_LO, 32'd4, "irq_add_res");
        wr(ADDR_POP, 32'h1);
        irq_chk(1'b1, "irq_still_high");
        irq_chk(1'b0, "irq_fall");
`endif

        idle(2);
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
